// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_pkg
// Purpose  : Shared definitions for the Fibonacci sequence controller: the
//            controller state enum and the operand-mux select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package fib_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT0 = 3'd1,
    INIT1 = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } fib_state_e;

  // Operand mux select encodings (A=0, B=1, C=sum, D=current term)
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_ctrl
// Purpose  : Sequential controller around an external 4-to-1 operand mux.
//            Steers the mux select and registers the mux output as the current
//            Fibonacci term, stopping before a term would overflow 'size' bits.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            start      - begin / restart the sequence (priority over step)
//            step       - advance one term while running
//            mux_o      - operand mux output (consumed as next term)
//            sel        - operand mux select
//            sum_out    - prev+curr truncated, feeds mux input C
//            term       - current term register, feeds mux input D
//            idx        - index n of term
//            term_valid - one-cycle pulse after each term update
//            busy       - high in INIT0 / INIT1 / RUN
//            done       - high once the sequence is exhausted
// Revision : 1.0 - initial release
// ============================================================================
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int size = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [size-1:0]   mux_o,
  output logic [1:0]        sel,
  output logic [size-1:0]   sum_out,
  output logic [size-1:0]   term,
  output logic [size-1:0]   idx,
  output logic              term_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [size-1:0] c_ONE = {{(size-1){1'b0}}, 1'b1};

  fib_state_e        state_q, state_d;
  logic [size-1:0]   prev_q,  prev_d;
  logic [size-1:0]   curr_q,  curr_d;
  logic [size-1:0]   idx_q,   idx_d;
  logic              tv_q,    tv_d;

  logic [size:0]     w_sum_wide;
  logic              w_carry;
  logic              w_update;

  // One extra bit so an overflowing sum is detected instead of wrapping into curr
  assign w_sum_wide = {1'b0, prev_q} + {1'b0, curr_q};
  assign w_carry    = w_sum_wide[size];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      curr_q  <= '0;
      idx_q   <= '0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      curr_q  <= curr_d;
      idx_q   <= idx_d;
      tv_q    <= tv_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and select decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sel      = SEL_HOLD;
    w_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT0;
      end

      INIT0: begin
        sel = SEL_ZERO;
        if (start) begin
          state_d = INIT0;
        end else begin
          w_update = 1'b1;
          idx_d    = '0;
          state_d  = INIT1;
        end
      end

      INIT1: begin
        sel = SEL_ONE;
        if (start) begin
          state_d = INIT0;
        end else begin
          w_update = 1'b1;
          idx_d    = c_ONE;
          state_d  = RUN;
        end
      end

      RUN: begin
        sel = step ? SEL_SUM : SEL_HOLD;
        if (start) begin
          state_d = INIT0;
        end else if (step) begin
          if (!w_carry) begin
            w_update = 1'b1;
            idx_d    = idx_q + c_ONE;
          end else begin
            // Next term would not fit: stop without touching the registers
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (start) state_d = INIT0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every update shifts the pair and captures the mux output
  always_comb begin
    prev_d = prev_q;
    curr_d = curr_q;
    tv_d   = 1'b0;
    if (w_update) begin
      prev_d = curr_q;
      curr_d = mux_o;
      tv_d   = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sum_out    = w_sum_wide[size-1:0];
  assign term       = curr_q;
  assign idx        = idx_q;
  assign term_valid = tv_q;
  assign busy       = (state_q == INIT0) || (state_q == INIT1) || (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule : fib_seq_ctrl
`default_nettype wire

// File: tb/tb_fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_ctrl
// Purpose  : Self-checking bench for fib_seq_ctrl at widths 4 and 8 sharing
//            the same control inputs, each closed through its own operand mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, step;

  always #5 clk = ~clk;

  // width-4 instance
  logic [3:0] mux4, sum4, term4, idx4;
  logic [1:0] sel4;
  logic       tv4, busy4, done4;
  // width-8 instance
  logic [7:0] mux8, sum8, term8, idx8;
  logic [1:0] sel8;
  logic       tv8, busy8, done8;

  // Purely combinational operand muxes: A=0, B=1, C=sum, D=term
  assign mux4 = (sel4 == 2'b00) ? 4'd0 : (sel4 == 2'b01) ? 4'd1 : (sel4 == 2'b10) ? sum4 : term4;
  assign mux8 = (sel8 == 2'b00) ? 8'd0 : (sel8 == 2'b01) ? 8'd1 : (sel8 == 2'b10) ? sum8 : term8;

  fib_seq_ctrl #(.size(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .mux_o(mux4),
    .sel(sel4), .sum_out(sum4), .term(term4), .idx(idx4),
    .term_valid(tv4), .busy(busy4), .done(done4)
  );

  fib_seq_ctrl #(.size(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .mux_o(mux8),
    .sel(sel8), .sum_out(sum8), .term(term8), .idx(idx8),
    .term_valid(tv8), .busy(busy8), .done(done8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: phase + the pair of most recent terms, advanced by the
  // Fibonacci recurrence with an explicit "does it still fit" test.
  // --------------------------------------------------------------------------
  localparam int P_IDLE = 0, P_INIT0 = 1, P_INIT1 = 2, P_RUN = 3, P_DONE = 4;
  int m_ph[2], m_prev[2], m_curr[2], m_idx[2], m_tv[2];
  int m_max[2] = '{15, 255};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE; m_prev[k] = 0; m_curr[k] = 0; m_idx[k] = 0; m_tv[k] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit st);
    for (int k = 0; k < 2; k++) begin
      m_tv[k] = 0;
      if (s) begin
        if (m_ph[k] != P_INIT0 || 1) m_ph[k] = P_INIT0;
      end else begin
        case (m_ph[k])
          P_INIT0: begin
            m_prev[k] = m_curr[k]; m_curr[k] = 0; m_idx[k] = 0; m_tv[k] = 1; m_ph[k] = P_INIT1;
          end
          P_INIT1: begin
            m_prev[k] = m_curr[k]; m_curr[k] = 1; m_idx[k] = 1; m_tv[k] = 1; m_ph[k] = P_RUN;
          end
          P_RUN: if (st) begin
            if (m_prev[k] + m_curr[k] <= m_max[k]) begin
              int nxt;
              nxt = m_prev[k] + m_curr[k];
              m_prev[k] = m_curr[k]; m_curr[k] = nxt; m_idx[k]++; m_tv[k] = 1;
            end else begin
              m_ph[k] = P_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge clk) if (rst_n) model_edge(start, step);

  task automatic cmp_one(input int k, input logic [1:0] sl, input logic [7:0] sm,
                         input logic [7:0] t, input logic [7:0] ix,
                         input logic v, input logic b, input logic d);
    int es;
    string w;
    w  = (k == 0) ? "w4" : "w8";
    case (m_ph[k])
      P_INIT0: es = 0;
      P_INIT1: es = 1;
      P_RUN:   es = step ? 2 : 3;
      default: es = 3;
    endcase
    chk({w, " sel"},        32'(sl), es);
    chk({w, " sum_out"},    32'(sm), (m_prev[k] + m_curr[k]) % (m_max[k] + 1));
    chk({w, " term"},       32'(t),  m_curr[k]);
    chk({w, " idx"},        32'(ix), m_idx[k]);
    chk({w, " term_valid"}, 32'(v),  m_tv[k]);
    chk({w, " busy"},       32'(b),  (m_ph[k] == P_INIT0 || m_ph[k] == P_INIT1 || m_ph[k] == P_RUN) ? 1 : 0);
    chk({w, " done"},       32'(d),  (m_ph[k] == P_DONE) ? 1 : 0);
  endtask

  task automatic check_all();
    cmp_one(0, sel4, {4'b0, sum4}, {4'b0, term4}, {4'b0, idx4}, tv4, busy4, done4);
    cmp_one(1, sel8, sum8, term8, idx8, tv8, busy8, done8);
  endtask

  // Apply inputs for one clock, then compare on the falling edge
  task automatic cyc(input bit s, input bit st);
    start = s;
    step  = st;
    @(negedge clk);
    check_all();
  endtask

  // Directed table for the width-4 full run, including a 3-cycle step gap
  typedef struct {
    bit s; bit st;
    int sel; int term; int idx; int tv; int busy; int done;
  } vec_t;
  vec_t vt[14];

  initial begin
    vt[0]  = '{1, 0, 0,  0, 0, 0, 1, 0};  // IDLE -> INIT0
    vt[1]  = '{0, 1, 1,  0, 0, 1, 1, 0};  // F(0) registered, step ignored
    vt[2]  = '{0, 1, 2,  1, 1, 1, 1, 0};  // F(1)
    vt[3]  = '{0, 1, 2,  1, 2, 1, 1, 0};
    vt[4]  = '{0, 1, 2,  2, 3, 1, 1, 0};
    vt[5]  = '{0, 1, 2,  3, 4, 1, 1, 0};
    vt[6]  = '{0, 0, 3,  3, 4, 0, 1, 0};  // gap: hold
    vt[7]  = '{0, 0, 3,  3, 4, 0, 1, 0};
    vt[8]  = '{0, 0, 3,  3, 4, 0, 1, 0};
    vt[9]  = '{0, 1, 2,  5, 5, 1, 1, 0};  // resume
    vt[10] = '{0, 1, 2,  8, 6, 1, 1, 0};
    vt[11] = '{0, 1, 2, 13, 7, 1, 1, 0};
    vt[12] = '{0, 1, 3, 13, 7, 0, 0, 1};  // 13+8 overflows -> DONE
    vt[13] = '{0, 1, 3, 13, 7, 0, 0, 1};  // step ignored in DONE

    // ---------------- reset with random inputs ----------------
    rst_n = 1'b0; start = 1'b0; step = 1'b0;
    model_reset();
    repeat (3) begin
      start = 1'($urandom);
      step  = 1'($urandom);
      @(negedge clk);
      check_all();
    end
    start = 1'b0; step = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // ---------------- table-driven full run, width 4 ----------------
    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].s, vt[i].st);
      chk($sformatf("vec%0d sel", i),  32'(sel4),  vt[i].sel);
      chk($sformatf("vec%0d term", i), 32'(term4), vt[i].term);
      chk($sformatf("vec%0d idx", i),  32'(idx4),  vt[i].idx);
      chk($sformatf("vec%0d tv", i),   32'(tv4),   vt[i].tv);
      chk($sformatf("vec%0d busy", i), 32'(busy4), vt[i].busy);
      chk($sformatf("vec%0d done", i), 32'(done4), vt[i].done);
    end

    // ---------------- width 8 runs on to its own limit ----------------
    for (int i = 0; i < 10 && m_ph[1] != P_DONE; i++) cyc(0, 1);
    chk("w8 last term", 32'(term8), 233);
    chk("w8 last idx",  32'(idx8),  13);
    chk("w8 done",      32'(done8), 1);

    // ---------------- restart from DONE ----------------
    cyc(1, 1);
    chk("done restart sel",  32'(sel4),  0);
    chk("done restart term", 32'(term4), 13);
    cyc(0, 1);
    chk("done restart F0",    32'(term4), 0);
    chk("done restart F0 tv", 32'(tv4),   1);
    for (int i = 0; i < 20 && !(m_ph[0] == P_RUN && m_idx[0] == 6); i++) cyc(0, 1);
    chk("reach term 8", 32'(term4), 8);

    // ---------------- start beats step in RUN ----------------
    cyc(1, 1);
    chk("prio sel",  32'(sel4),  0);
    chk("prio tv",   32'(tv4),   0);
    chk("prio term", 32'(term4), 8);
    cyc(0, 0);
    chk("prio F0", 32'(term4), 0);
    cyc(0, 0);
    chk("prio F1",     32'(term4), 1);
    chk("prio F1 idx", 32'(idx4),  1);

    // ---------------- async reset between edges ----------------
    for (int i = 0; i < 20 && m_idx[0] != 5; i++) cyc(0, 1);
    chk("reach term 5", 32'(term4), 5);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("async term",  32'(term4), 0);
    chk("async idx",   32'(idx4),  0);
    chk("async sel",   32'(sel4),  3);
    chk("async tv",    32'(tv4),   0);
    chk("async busy",  32'(busy4), 0);
    chk("async sum",   32'(sum4),  0);
    chk("async term8", 32'(term8), 0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (2) begin
      cyc(0, 1);
      chk("post-reset busy", 32'(busy4), 0);
      chk("post-reset term", 32'(term4), 0);
    end

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
      end else begin
        cyc($urandom_range(15) == 0, $urandom_range(3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fib_seq_ctrl
`default_nettype wire
